morse_frame_decode: RTL

//  Downstream consumer of the envelope-threshold stage: takes each 1024-bit on/off frame
//  (CHECK_DOE + 16x64-bit words, concatenated here as one bus) and run-length decodes it.

---
 rtl/morse_frame_decode_if.sv | 27 ++
 rtl/morse_frame_decode.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_frame_decode_if.sv
// Frame-in / character-out signal bundle for the Morse run-length decoder.
// The master side is the threshold stage plus the text formatter; the slave side is the decoder.
interface morse_frame_decode_if;
  logic          CHECK_DOE;
  logic [1023:0] CHECK_DAT;
  logic          BUSY;
  logic          OUT_VLD;
  logic [5:0]    OUT_CODE;
  logic [2:0]    OUT_LEN;
  logic          OUT_WORD;
  logic          OUT_EOF;
  logic          OUT_ERR;
  logic          FRAME_DONE;
  logic          FRAME_DROP;

  modport master (
    output CHECK_DOE, CHECK_DAT,
    input  BUSY, OUT_VLD, OUT_CODE, OUT_LEN, OUT_WORD, OUT_EOF, OUT_ERR,
           FRAME_DONE, FRAME_DROP
  );

  modport slave (
    input  CHECK_DOE, CHECK_DAT,
    output BUSY, OUT_VLD, OUT_CODE, OUT_LEN, OUT_WORD, OUT_EOF, OUT_ERR,
           FRAME_DONE, FRAME_DROP
  );
endinterface

// File: rtl/morse_frame_decode.sv
// Morse frame decoder: latches a 1024-sample on/off frame, scans it MSB-first one bit per
// cycle, run-length classifies marks (dot/dash) and gaps (element/letter/word breaks) and
// emits one registered character code per letter. Each frame is decoded independently.
module morse_frame_decode #(
  parameter int unsigned MIN_RUN      = 3,
  parameter int unsigned DOT_MAX      = 24,
  parameter int unsigned CHAR_GAP_MIN = 24,
  parameter int unsigned WORD_GAP_MIN = 56
) (
  input logic                 CLK,
  input logic                 RST_N,
  morse_frame_decode_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [10:0] MIN_RUN_C   = 11'(MIN_RUN);
  localparam logic [10:0] DOT_MAX_C   = 11'(DOT_MAX);
  localparam logic [10:0] CHAR_GAP_C  = 11'(CHAR_GAP_MIN);
  localparam logic [10:0] WORD_GAP_C  = 11'(WORD_GAP_MIN);
  localparam logic [10:0] RUN_SAT_C   = 11'd1024;

  // Scan state
  logic [1:0]    state_q, state_d;
  logic [1023:0] shreg_q, shreg_d;
  logic [9:0]    bit_cnt_q, bit_cnt_d;
  logic          level_q, level_d;
  logic [10:0]   run_q, run_d;
  logic [10:0]   prev_gap_q, prev_gap_d;
  logic [5:0]    code_q, code_d;
  logic [2:0]    len_q, len_d;
  logic          err_q, err_d;

  // Registered outputs
  logic          out_vld_q, out_vld_d;
  logic [5:0]    out_code_q, out_code_d;
  logic [2:0]    out_len_q, out_len_d;
  logic          out_word_q, out_word_d;
  logic          out_eof_q, out_eof_d;
  logic          out_err_q, out_err_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_drop_q, frame_drop_d;

  // Combinational helpers
  logic          cur_bit;
  logic          start;
  logic          glitch;
  logic [10:0]   merged_gap;
  logic [5:0]    app_code;
  logic [2:0]    app_len;
  logic          app_err;
  logic          emit;
  logic [5:0]    emit_code;
  logic [2:0]    emit_len;
  logic          emit_err;
  logic          emit_word;
  logic          emit_eof;

  function automatic logic [10:0] sat_add(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, RUN_SAT_C}) ? RUN_SAT_C : s[10:0];
  endfunction

  assign cur_bit = shreg_q[1023];

  // Element produced if the mark run held in run_q closes now; a seventh element is dropped
  always_comb begin
    app_code = code_q;
    app_len  = len_q;
    app_err  = 1'b1;
    if (len_q != 3'd6) begin
      app_code = {code_q[4:0], (run_q > DOT_MAX_C)};
      app_len  = len_q + 3'd1;
      app_err  = err_q;
    end
  end

  // A too-short mark is folded back into the gap that preceded it
  assign glitch     = (run_q < MIN_RUN_C);
  assign merged_gap = sat_add(prev_gap_q, run_q);

  // FSM, run-length tracking, element assembly and character emission
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    level_d      = level_q;
    run_d        = run_q;
    prev_gap_d   = prev_gap_q;
    code_d       = code_q;
    len_d        = len_q;
    err_d        = err_q;
    frame_done_d = 1'b0;
    frame_drop_d = 1'b0;
    start        = 1'b0;
    emit         = 1'b0;
    emit_code    = code_q;
    emit_len     = len_q;
    emit_err     = err_q;
    emit_word    = 1'b0;
    emit_eof     = 1'b0;

    case (state_q)
      IDLE: begin
        start = bus.CHECK_DOE;
      end

      SCAN: begin
        frame_drop_d = bus.CHECK_DOE;
        shreg_d      = {shreg_q[1022:0], 1'b0};
        bit_cnt_d    = bit_cnt_q + 10'd1;
        if (bit_cnt_q == 10'd1023) state_d = DONE;

        if (cur_bit == level_q) begin
          run_d = sat_add(run_q, 11'd1);
        end else if (level_q) begin
          // Mark closes on a 0 bit
          level_d = 1'b0;
          if (glitch) begin
            run_d = sat_add(merged_gap, 11'd1);
          end else begin
            code_d = app_code;
            len_d  = app_len;
            err_d  = app_err;
            run_d  = 11'd1;
          end
        end else begin
          // Gap closes on a 1 bit
          level_d    = 1'b1;
          prev_gap_d = run_q;
          run_d      = 11'd1;
          if ((run_q >= CHAR_GAP_C) && (len_q != 3'd0)) begin
            emit      = 1'b1;
            emit_word = (run_q >= WORD_GAP_C);
            code_d    = '0;
            len_d     = '0;
            err_d     = 1'b0;
          end
        end
      end

      DONE: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
        if (level_q && !glitch) begin
          emit      = 1'b1;
          emit_code = app_code;
          emit_len  = app_len;
          emit_err  = app_err;
          emit_eof  = 1'b1;
        end else if (len_q != 3'd0) begin
          // Trailing glitch counts as part of the final gap
          emit      = 1'b1;
          emit_eof  = 1'b1;
          emit_word = ((level_q ? merged_gap : run_q) >= WORD_GAP_C);
        end
        code_d = '0;
        len_d  = '0;
        err_d  = 1'b0;
        start  = bus.CHECK_DOE;
      end

      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d    = SCAN;
      shreg_d    = bus.CHECK_DAT;
      bit_cnt_d  = '0;
      level_d    = 1'b0;
      run_d      = '0;
      prev_gap_d = '0;
      code_d     = '0;
      len_d      = '0;
      err_d      = 1'b0;
    end
  end

  // Output character fields load only when a character is emitted
  always_comb begin
    out_vld_d  = emit;
    out_code_d = out_code_q;
    out_len_d  = out_len_q;
    out_word_d = out_word_q;
    out_eof_d  = out_eof_q;
    out_err_d  = out_err_q;
    if (emit) begin
      out_code_d = emit_code;
      out_len_d  = emit_len;
      out_word_d = emit_word;
      out_eof_d  = emit_eof;
      out_err_d  = emit_err;
    end
  end

  // State and output registers, cleared immediately by reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      level_q      <= 1'b0;
      run_q        <= '0;
      prev_gap_q   <= '0;
      code_q       <= '0;
      len_q        <= '0;
      err_q        <= 1'b0;
      out_vld_q    <= 1'b0;
      out_code_q   <= '0;
      out_len_q    <= '0;
      out_word_q   <= 1'b0;
      out_eof_q    <= 1'b0;
      out_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      level_q      <= level_d;
      run_q        <= run_d;
      prev_gap_q   <= prev_gap_d;
      code_q       <= code_d;
      len_q        <= len_d;
      err_q        <= err_d;
      out_vld_q    <= out_vld_d;
      out_code_q   <= out_code_d;
      out_len_q    <= out_len_d;
      out_word_q   <= out_word_d;
      out_eof_q    <= out_eof_d;
      out_err_q    <= out_err_d;
      frame_done_q <= frame_done_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  assign bus.BUSY       = (state_q == SCAN);
  assign bus.OUT_VLD    = out_vld_q;
  assign bus.OUT_CODE   = out_code_q;
  assign bus.OUT_LEN    = out_len_q;
  assign bus.OUT_WORD   = out_word_q;
  assign bus.OUT_EOF    = out_eof_q;
  assign bus.OUT_ERR    = out_err_q;
  assign bus.FRAME_DONE = frame_done_q;
  assign bus.FRAME_DROP = frame_drop_q;

endmodule
